vga_output_stage: RTL
=====================

Name: vga_output_stage

Overview:
- Downstream consumer of the pixel-timing counters: column count, row count, frame-buffer address and pixel clock.
- Detects each pixel tick, decodes blanking and active-low sync for 640x480@60 (800x525 total), and issues one frame-buffer read per visible pixel.
- Registers the returned colour together with the sync/blank signals, all aligned, so the VGA DAC/pins are driven glitch-free from flops.

Parameters:
H_VISIBLE, 640, last visible column + 1
H_SYNC_START, 656, first column with hsync asserted
H_SYNC_END, 752, first column after hsync
V_VISIBLE, 480, last visible row + 1
V_SYNC_START, 490, first row with vsync asserted
V_SYNC_END, 492, first row after vsync
DATA_W, 8, frame-buffer pixel width (RGB 3:3:2)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
enable  in  1  stage enable; low freezes pipeline
pixel_clk  in  1  divided pixel clock level; a rising edge marks one pixel tick
col_cnt  in  10  current column, 0..799
row_cnt  in  10  current row, 0..524
pix_addr  in  20  frame-buffer address of current pixel
rd_en  out  1  one-clk frame-buffer read strobe
rd_addr  out  20  read address, valid while rd_en=1
rd_valid  in  1  read data valid, expected exactly 1 clk after rd_en
rd_data  in  DATA_W  read data
vga_r  out  3  red, = pixel[7:5]
vga_g  out  3  green, = pixel[4:2]
vga_b  out  2  blue, = pixel[1:0]
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low
blank_n  out  1  high during visible region
frame_start  out  1  one-clk pulse when pixel (0,0) reaches outputs
underrun  out  1  sticky: visible pixel read returned no rd_valid

Behaviour:
- Single clock domain.
- Reset is asynchronous, active-low on n_rst. Reset values:
  - hsync_n=1, vsync_n=1, blank_n=0, RGB=0
  - rd_en=0, rd_addr=0, frame_start=0, underrun=0
  - pixel_clk edge-detect register=0
  - all pipeline valid bits=0
- Tick detection: tick = pixel_clk & ~pclk_q, where pclk_q is registered every clk. pclk_q updates regardless of enable, so no false tick follows re-enable.
- Pipeline, for a tick in cycle T with enable=1:
  - S1, end of T: capture active = (col<H_VISIBLE && row<V_VISIBLE), hs = col in [H_SYNC_START,H_SYNC_END), vs = row in [V_SYNC_START,V_SYNC_END), first = (col==0 && row==0), and pix_addr. Set s1_v=1.
  - Cycle T+1: rd_en=1 iff s1_v && active, with rd_addr=captured addr. S1 fields shift to S2 at end of T+1.
  - End of T+2: if S2 valid, load the outputs:
    - blank_n=active, hsync_n=~hs, vsync_n=~vs
    - RGB = rd_data if (active && rd_valid), else 0
    - frame_start=first, high for 1 clk only
  - Net latency: counts sampled at tick T appear on the outputs from cycle T+3. Outputs hold until the next load (2 clk later at a 2:1 divide).
- Counts outside range (col>799 or row>524): blanked, syncs inactive, no read.
- Missing rd_valid on an active pixel: output black and set underrun=1; it stays set until reset.
- rd_valid when no read is pending: ignored.
- enable=0:
  - no new ticks accepted, rd_en forced 0, pipeline stages and outputs hold.
  - A read already issued still completes and loads in T+2.
- Reset mid-frame: everything returns to reset values immediately. The first load after release follows the normal 3-cycle latency.
- Simultaneous tick and S2 load is the normal case; both occur in the same clk without interaction.

Test Plan:
- Reset held, pixel_clk toggling -> hsync_n=vsync_n=1, blank_n=0, RGB=0, rd_en=0 throughout.
- Tick at col=5,row=10,addr=0x01405, rd_data=0xE3 with rd_valid 1 clk after rd_en -> rd_en at T+1 with rd_addr=0x01405; from T+3 vga_r=7, vga_g=0, vga_b=3, blank_n=1.
- Full line sweep col 0..799, row=0 -> blank_n low from col 640; hsync_n low for exactly cols 656..751 (96 pixels, 192 clk); no rd_en for col>=640.
- Full frame sweep -> vsync_n low for rows 490..491 only; frame_start pulses once per frame, 3 clk after the (0,0) tick; 307200 rd_en pulses per frame.
- Visible pixel with rd_valid withheld -> RGB=0 for that pixel, underrun rises and stays high across the next frame until n_rst.
- enable dropped for 10 clk mid-line, then reasserted -> outputs frozen during the gap, no rd_en, no spurious tick on re-enable; async n_rst pulse mid-line returns all outputs to reset values in the same cycle.

Source files
------------

// File: rtl/vga_output_stage.sv
// VGA output stage: turns pixel-timing counts into one frame-buffer read per visible pixel
// and drives colour, sync and blank from aligned flops three clocks after each pixel tick.
module vga_output_stage #(
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic              pixel_clk,
    input  logic [9:0]        col_cnt,
    input  logic [9:0]        row_cnt,
    input  logic [19:0]       pix_addr,
    output logic              rd_en,
    output logic [19:0]       rd_addr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic [2:0]        vga_r,
    output logic [2:0]        vga_g,
    output logic [1:0]        vga_b,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              blank_n,
    output logic              frame_start,
    output logic              underrun
);

    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE   = 10'(V_SYNC_END);

    logic              pclk_q;
    logic              tick;
    logic              cur_active;
    logic              cur_hs;
    logic              cur_vs;
    logic              cur_first;

    logic              s1_v;
    logic              s1_active;
    logic              s1_hs;
    logic              s1_vs;
    logic              s1_first;
    logic [19:0]       s1_addr;

    logic              s2_v;
    logic              s2_rd;
    logic              s2_active;
    logic              s2_hs;
    logic              s2_vs;
    logic              s2_first;
    logic              s2_load;

    logic [DATA_W-1:0] pixel_q;

    assign tick = enable & pixel_clk & ~pclk_q;

    // Out-of-range counts fall outside every window, so they decode as blank with no read.
    always_comb begin
        cur_active = 1'b0;
        cur_hs     = 1'b0;
        cur_vs     = 1'b0;
        cur_first  = 1'b0;
        cur_active = (col_cnt < H_VIS) && (row_cnt < V_VIS);
        cur_hs     = (col_cnt >= H_SS) && (col_cnt < H_SE);
        cur_vs     = (row_cnt >= V_SS) && (row_cnt < V_SE);
        cur_first  = (col_cnt == 10'd0) && (row_cnt == 10'd0);
    end

    // Tracks pixel_clk even while disabled so re-enabling cannot see a stale low level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pclk_q <= 1'b0;
        end else begin
            pclk_q <= pixel_clk;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_v      <= 1'b0;
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_first  <= 1'b0;
            s1_addr   <= '0;
        end else if (enable) begin
            s1_v <= tick;
            if (tick) begin
                s1_active <= cur_active;
                s1_hs     <= cur_hs;
                s1_vs     <= cur_vs;
                s1_first  <= cur_first;
                s1_addr   <= pix_addr;
            end
        end
    end

    assign rd_en   = s1_v & s1_active & enable;
    assign rd_addr = s1_addr;

    // A read already in flight must still load when enable drops, then S2 empties.
    assign s2_load = s2_v & (enable | s2_rd);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_v      <= 1'b0;
            s2_rd     <= 1'b0;
            s2_active <= 1'b0;
            s2_hs     <= 1'b0;
            s2_vs     <= 1'b0;
            s2_first  <= 1'b0;
        end else if (enable) begin
            s2_v      <= s1_v;
            s2_rd     <= rd_en;
            s2_active <= s1_active;
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;
            s2_first  <= s1_first;
        end else if (s2_load) begin
            s2_v  <= 1'b0;
            s2_rd <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pixel_q     <= '0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= s2_load & s2_first;
            if (s2_load) begin
                blank_n <= s2_active;
                hsync_n <= ~s2_hs;
                vsync_n <= ~s2_vs;
                pixel_q <= (s2_rd && rd_valid) ? rd_data : '0;
                if (s2_rd && !rd_valid) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    assign vga_r = pixel_q[7:5];
    assign vga_g = pixel_q[4:2];
    assign vga_b = pixel_q[1:0];

endmodule
